load_writeback: RTL

Memory/writeback boundary stage. It takes the combinational data-bus request and `plr_w` record produced by the memory stage and runs the `dbus` handshake. It stalls the upstream pipeline while a load or store is outstanding, and extracts and sign- or zero-extends load data. It registers the final writeback record (`w_valid`, `w_dst`, `w_data`, `w_we`) for the register file and the hazard unit.

---
 rtl/load_writeback_pkg.sv | 40 ++++
 rtl/load_writeback.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/load_writeback_pkg.sv
// Shared record and data-bus types for the memory/writeback boundary.
package load_writeback_pkg;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] valE;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] pc;
    logic [2:0]  btype;
    logic [4:0]  ExcCode;
    logic [31:0] erraddr;
    logic        inssl;
  } plr_w;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

endpackage

// File: rtl/load_writeback.sv
// Memory/writeback boundary: runs the dbus handshake, stalls upstream while a
// transaction is outstanding, extends load data and registers the W record.
module load_writeback
  import load_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       m_valid,
  input  plr_w       r_m,
  input  logic       m_ok,
  input  dbus_req_t  dreq_in,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  input  logic       flush,
  output logic       m_stall,
  output logic       w_valid,
  output plr_w       w_info,
  output logic [4:0] w_dst,
  output logic [31:0] w_data,
  output logic       w_we
);

  // dbus handshake: dreq holds valid and every field stable from issue until
  // the cycle dresp.data_ok=1; addr_ok plays no part in sequencing.
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t    state_q, state_d;
  dbus_req_t req_q;
  plr_w      hold_rec_q;
  logic      hold_ok_q;

  logic        issue;
  logic        load_w;
  logic        mem_done;
  logic        valid_d;
  plr_w        src_rec;
  logic        src_ok;
  logic        is_load, is_store;
  logic [4:0]  dst_d;
  logic [31:0] data_d;
  logic        we_d;
  logic        unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

  function automatic logic [31:0] load_extract(input logic [5:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    dreq     = '0;
    m_stall  = 1'b0;
    load_w   = 1'b0;
    mem_done = 1'b0;
    valid_d  = 1'b0;
    src_rec  = r_m;
    src_ok   = m_ok;
    issue    = (state_q == IDLE) && m_valid && dreq_in.valid &&
               (r_m.ExcCode == '0) && !flush;
    case (state_q)
      IDLE: begin
        if (issue) begin
          dreq = dreq_in;
          if (dresp.data_ok) begin
            load_w   = 1'b1;
            mem_done = 1'b1;
            valid_d  = 1'b1;
          end else begin
            state_d = WAIT;
            m_stall = 1'b1;
          end
        end else begin
          load_w  = 1'b1;
          valid_d = m_valid && !flush;
        end
      end
      WAIT: begin
        dreq    = req_q;
        src_rec = hold_rec_q;
        src_ok  = hold_ok_q;
        if (dresp.data_ok) begin
          state_d  = IDLE;
          load_w   = !flush;
          mem_done = 1'b1;
          valid_d  = !flush;
        end else begin
          m_stall = 1'b1;
          if (flush) state_d = DRAIN;
        end
      end
      DRAIN: begin
        dreq = req_q;
        if (dresp.data_ok) state_d = IDLE;
        else               m_stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!resetn) begin
      dreq    = '0;
      m_stall = 1'b0;
    end
  end

  always_comb begin
    is_load  = (src_rec.opcode == OP_LW) || (src_rec.opcode == OP_LB) ||
               (src_rec.opcode == OP_LH) || (src_rec.opcode == OP_LBU) ||
               (src_rec.opcode == OP_LHU);
    is_store = (src_rec.opcode == OP_SW) || (src_rec.opcode == OP_SB) ||
               (src_rec.opcode == OP_SH);
    dst_d    = is_load ? src_rec.dstM : src_rec.dstE;
    data_d   = (is_load && mem_done) ?
               load_extract(src_rec.opcode, src_rec.valE[1:0], dresp.data) :
               src_rec.valE;
    // Exceptions still travel downstream as valid, but never write a register.
    we_d     = valid_d && (src_rec.ExcCode == '0) && !is_store &&
               (is_load || src_ok) && (dst_d != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_q      <= '0;
      hold_rec_q <= '0;
      hold_ok_q  <= 1'b0;
      w_valid    <= 1'b0;
      w_info     <= '0;
      w_dst      <= '0;
      w_data     <= '0;
      w_we       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        req_q      <= dreq_in;
        hold_rec_q <= r_m;
        hold_ok_q  <= m_ok;
      end
      if (load_w) begin
        w_valid <= valid_d;
        w_info  <= src_rec;
        w_dst   <= dst_d;
        w_data  <= data_d;
        w_we    <= we_d;
      end else begin
        // Non-completing cycles drop valid/we so each write is a single pulse.
        w_valid <= 1'b0;
        w_we    <= 1'b0;
      end
    end
  end

endmodule
